// File: rtl/dino_pkg.sv
// Shared encodings for the dino game controller: game states, jump phases
// and the saturation ceiling of the 4-digit BCD score.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OVER = 2'd2
  } game_st_t;

  typedef enum logic [1:0] {
    J_GROUND = 2'd0,
    J_RISE   = 2'd1,
    J_PEAK   = 2'd2,
    J_FALL   = 2'd3
  } jump_st_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear; holds at 9999 instead of
// wrapping so a long game never reads back as a low score.
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        inc,
  output logic [15:0] value
);

  logic [15:0] nxt;
  logic        carry;

  // Ripple the increment from the units digit upward, stopping at the first
  // digit that does not roll over from 9.
  always_comb begin
    nxt   = value;
    carry = inc && (value != BCD_MAX);
    for (int d = 0; d < 4; d++) begin
      if (carry) begin
        if (value[d*4 +: 4] == 4'd9) begin
          nxt[d*4 +: 4] = 4'd0;
        end else begin
          nxt[d*4 +: 4] = value[d*4 +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Dino game controller: game FSM (IDLE/RUN/OVER), jump FSM, collision
// detection, BCD score and high score, all stepped by the shared game tick.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int DINO_COL = 0,
  parameter int JUMP_H   = 3,
  parameter int HANG     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [7:0]  down,
  input  logic        start_btn,
  input  logic        jump_btn,
  output logic [2:0]  dino_h,
  output logic        running,
  output logic        game_over,
  output logic        collide,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_score_bcd
);

  game_st_t    st, st_nx;
  jump_st_t    js, js_nx;
  logic [2:0]  h_nx;
  logic [2:0]  hang, hang_nx;
  logic        pend, pend_nx;
  logic        coll_nx;
  logic [15:0] hi_nx;
  logic        score_clr, score_inc;
  logic        score_gt, decided;
  logic        down_unused;

  assign down_unused = ^down;
  assign running     = (st == ST_RUN);
  assign game_over   = (st == ST_OVER);

  bcd_counter4 u_score (
    .clk   (clk),
    .reset (reset),
    .clear (score_clr),
    .inc   (score_inc),
    .value (score_bcd)
  );

  // BCD magnitude compare: the first differing digit from the top decides.
  always_comb begin
    score_gt = 1'b0;
    decided  = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      if (!decided && (score_bcd[d*4 +: 4] != hi_score_bcd[d*4 +: 4])) begin
        score_gt = (score_bcd[d*4 +: 4] > hi_score_bcd[d*4 +: 4]);
        decided  = 1'b1;
      end
    end
  end

  always_comb begin
    st_nx     = st;
    js_nx     = js;
    h_nx      = dino_h;
    hang_nx   = hang;
    pend_nx   = pend;
    coll_nx   = 1'b0;
    hi_nx     = hi_score_bcd;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (st)
      ST_IDLE, ST_OVER: begin
        if (start_btn) begin
          st_nx     = ST_RUN;
          score_clr = 1'b1;
          js_nx     = J_GROUND;
          h_nx      = 3'd0;
          hang_nx   = 3'd0;
          pend_nx   = 1'b0;
        end
      end
      ST_RUN: begin
        pend_nx = pend | jump_btn;
        if (tick) begin
          // Collision beats a same-tick launch, so the dino never leaves the ground.
          if (down[DINO_COL] && (dino_h == 3'd0)) begin
            st_nx   = ST_OVER;
            coll_nx = 1'b1;
            if (score_gt) hi_nx = score_bcd;
          end else begin
            score_inc = 1'b1;
            unique case (js)
              J_GROUND: begin
                if (pend) begin
                  pend_nx = jump_btn;
                  h_nx    = 3'd1;
                  if (JUMP_H <= 1) begin
                    js_nx   = (HANG == 0) ? J_FALL : J_PEAK;
                    hang_nx = 3'(HANG);
                  end else begin
                    js_nx = J_RISE;
                  end
                end
              end
              J_RISE: begin
                h_nx = dino_h + 3'd1;
                if ((dino_h + 3'd1) == 3'(JUMP_H)) begin
                  js_nx   = (HANG == 0) ? J_FALL : J_PEAK;
                  hang_nx = 3'(HANG);
                end
              end
              J_PEAK: begin
                hang_nx = hang - 3'd1;
                if (hang <= 3'd1) js_nx = J_FALL;
              end
              J_FALL: begin
                h_nx = dino_h - 3'd1;
                if (dino_h == 3'd1) js_nx = J_GROUND;
              end
            endcase
          end
        end
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      st           <= ST_IDLE;
      js           <= J_GROUND;
      dino_h       <= 3'd0;
      hang         <= 3'd0;
      pend         <= 1'b0;
      collide      <= 1'b0;
      hi_score_bcd <= '0;
    end else begin
      st           <= st_nx;
      js           <= js_nx;
      dino_h       <= h_nx;
      hang         <= hang_nx;
      pend         <= pend_nx;
      collide      <= coll_nx;
      hi_score_bcd <= hi_nx;
    end
  end

endmodule
